// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART: framed TX shifter, oversampled RX, show-ahead RX FIFO
// with sticky status flags. All logic is on rising clk and reset asynchronously by rst.
module uart_cfg #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_interrupt,
    output logic              parity_err,
    output logic              framing_err,
    output logic              overrun,
    input  logic              clear_interrupt
);
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = 4;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t             tx_state_reg, tx_state_next;
    logic [CNT_W-1:0]   tx_cnt_reg;
    logic [BIT_W-1:0]   tx_bit_reg;
    logic [DATA_W-1:0]  tx_shift_reg;
    logic               tx_par_reg;
    logic               tx_reg, tx_line_next;
    logic               tx_bit_end;

    assign tx_bit_end = (tx_cnt_reg == CNT_LAST);
    assign tx_ready   = (tx_state_reg == S_IDLE);
    assign tx         = tx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state_reg <= S_IDLE;
        else     tx_state_reg <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            S_IDLE:   if (tx_valid) tx_state_next = S_START;
            S_START:  if (tx_bit_end) tx_state_next = S_DATA;
            S_DATA:   if (tx_bit_end && tx_bit_reg == BIT_LAST)
                          tx_state_next = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_state_next = S_STOP;
            S_STOP:   if (tx_bit_end && tx_bit_reg == STOP_LAST) tx_state_next = S_IDLE;
            default:  tx_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_line_next = 1'b1;
        case (tx_state_reg)
            S_START:  tx_line_next = 1'b0;
            S_DATA:   tx_line_next = tx_shift_reg[0];
            S_PARITY: tx_line_next = tx_par_reg;
            default:  tx_line_next = 1'b1;
        endcase
    end

    // The line is registered, so it trails the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_reg       <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
        end else begin
            tx_reg <= tx_line_next;
            if (tx_valid && tx_ready) begin
                tx_shift_reg <= tx_data;
                tx_par_reg   <= (^tx_data) ^ PAR_INV;
                tx_cnt_reg   <= '0;
                tx_bit_reg   <= '0;
            end else if (tx_state_reg != S_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt_reg <= '0;
                    if (tx_state_reg == S_DATA) begin
                        tx_shift_reg <= tx_shift_reg >> 1;
                        tx_bit_reg   <= (tx_bit_reg == BIT_LAST) ? '0 : tx_bit_reg + BIT_W'(1);
                    end else if (tx_state_reg == S_STOP) begin
                        tx_bit_reg <= tx_bit_reg + BIT_W'(1);
                    end
                end else begin
                    tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- receiver ----------------
    logic [2:0]         sync_chain;
    logic               sync_rx, rx_fall;
    state_t             rx_state_reg, rx_state_next;
    logic [CNT_W-1:0]   rx_cnt_reg;
    logic [BIT_W-1:0]   rx_bit_reg;
    logic [DATA_W-1:0]  rx_shift_reg;
    logic               rx_par_reg;
    logic               rx_sample, rx_frame_done;
    logic               evt_push_reg, evt_perr_reg, evt_ferr_reg;

    assign sync_rx = sync_chain[1];
    assign rx_fall = sync_chain[2] & ~sync_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_chain <= 3'b111;
        else     sync_chain <= {sync_chain[1:0], rx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state_reg <= S_IDLE;
        else     rx_state_reg <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            S_IDLE:   if (rx_fall) rx_state_next = S_START;
            S_START:  if (rx_cnt_reg == CNT_HALF) rx_state_next = sync_rx ? S_IDLE : S_DATA;
            S_DATA:   if (rx_sample && rx_bit_reg == BIT_LAST)
                          rx_state_next = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (rx_sample) rx_state_next = S_STOP;
            S_STOP:   if (rx_sample) rx_state_next = S_IDLE;
            default:  rx_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_sample     = 1'b0;
        rx_frame_done = 1'b0;
        case (rx_state_reg)
            S_START:  rx_sample = (rx_cnt_reg == CNT_HALF);
            S_DATA, S_PARITY: rx_sample = (rx_cnt_reg == CNT_LAST);
            S_STOP: begin
                rx_sample     = (rx_cnt_reg == CNT_LAST);
                rx_frame_done = rx_sample;
            end
            default: rx_sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_par_reg   <= 1'b0;
            evt_push_reg <= 1'b0;
            evt_perr_reg <= 1'b0;
            evt_ferr_reg <= 1'b0;
        end else begin
            evt_push_reg <= rx_frame_done && sync_rx;
            evt_perr_reg <= rx_frame_done && sync_rx && PAR_EN &&
                            (rx_par_reg != ((^rx_shift_reg) ^ PAR_INV));
            evt_ferr_reg <= rx_frame_done && !sync_rx;
            if (rx_state_reg == S_IDLE) begin
                rx_cnt_reg <= '0;
                rx_bit_reg <= '0;
            end else if (rx_sample) begin
                rx_cnt_reg <= '0;
                if (rx_state_reg == S_DATA) begin
                    rx_shift_reg <= {sync_rx, rx_shift_reg[DATA_W-1:1]};
                    rx_bit_reg   <= rx_bit_reg + BIT_W'(1);
                end
                if (rx_state_reg == S_PARITY) rx_par_reg <= sync_rx;
            end else begin
                rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [ADDR_W:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [DATA_W-1:0]  head_reg;
    logic               fifo_full, fifo_empty, fifo_pop, fifo_push, head_bypass;

    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full   = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                         (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign fifo_pop    = !fifo_empty && rx_ready;
    assign fifo_push   = evt_push_reg && (!fifo_full || fifo_pop);
    assign rd_ptr_next = rd_ptr_reg + (ADDR_W+1)'(fifo_pop);
    // The new head is the word being written when it lands on the next read slot.
    assign head_bypass = fifo_push && (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
    assign rx_valid    = !fifo_empty;
    assign rx_data     = head_reg;

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_reg[ADDR_W-1:0]] <= rx_shift_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + (ADDR_W+1)'(fifo_push);
            rd_ptr_reg <= rd_ptr_next;
            if (head_bypass)   head_reg <= rx_shift_reg;
            else if (fifo_pop) head_reg <= fifo_mem[rd_ptr_next[ADDR_W-1:0]];
        end
    end

    // ---------------- sticky flags: a set beats a same-cycle clear ----------------
    logic [3:0] flag_set, flag_reg;
    assign flag_set = {evt_push_reg && fifo_full && !fifo_pop, evt_ferr_reg, evt_perr_reg, fifo_push};

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_flag
        logic flag_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                  flag_q <= 1'b0;
            else if (flag_set[gi])    flag_q <= 1'b1;
            else if (clear_interrupt) flag_q <= 1'b0;
        end
        assign flag_reg[gi] = flag_q;
    end

    assign rx_interrupt = flag_reg[0];
    assign parity_err   = flag_reg[1];
    assign framing_err  = flag_reg[2];
    assign overrun      = flag_reg[3];
endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: default instance (bench-driven or looped RX) plus a
// DATA_W=5 / CLK_DIV=4 / odd parity / 2-stop instance in self-loopback.
module tb_uart_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, bench_rx, loop_sel, dut_rx;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, tx_s, rx_valid, rx_ready;
    logic       rx_interrupt, parity_err, framing_err, overrun, clear_interrupt;

    logic [4:0] tx_data2, rx_data2;
    logic       tx_valid2, tx_ready2, tx2, rx_valid2, rx_ready2;
    logic       rx_int2, perr2, ferr2, ovr2, clr2;

    assign dut_rx = loop_sel ? tx_s : bench_rx;

    uart_cfg dut (
        .clk(clk), .rst(rst), .rx(dut_rx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx_s),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_interrupt(rx_interrupt), .parity_err(parity_err),
        .framing_err(framing_err), .overrun(overrun),
        .clear_interrupt(clear_interrupt)
    );

    uart_cfg #(.DATA_W(5), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1),
               .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .rx(tx2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
        .rx_interrupt(rx_int2), .parity_err(perr2),
        .framing_err(ferr2), .overrun(ovr2),
        .clear_interrupt(clr2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {overrun, framing_err, parity_err, rx_interrupt};
    endfunction

    task automatic wait_tx_idle();
        int w = 0;
        while (!tx_ready && w < 1000) begin tick(1); w++; end
        check("tx_ready_timeout", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send_tx(input logic [7:0] d);
        wait_tx_idle();
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            bench_rx = f[k];
            tick(16);
        end
        bench_rx = 1'b1;
        tick(8);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_interrupt = 1'b1;
        tick(1);
        clear_interrupt = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] frame;
        int          low_cnt;
        int          w;
        logic [7:0]  ov_word [9];

        rst = 1'b1; bench_rx = 1'b1; loop_sel = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clear_interrupt = 1'b0;
        tx_data2 = '0; tx_valid2 = 1'b0; rx_ready2 = 1'b0; clr2 = 1'b0;
        tick(3);
        check("rst_tx", {31'd0, tx_s}, 32'd1);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_flags", {28'd0, flags()}, 32'd0);
        check("rst_tx2", {31'd0, tx2}, 32'd1);
        @(negedge clk) rst = 1'b0;
        tick(2);

        // TX frame 0xA5: start, LSB-first data, even parity 0, stop
        frame = {1'b1, 1'b0, 8'hA5, 1'b0};
        @(negedge clk);
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        low_cnt = 0;
        for (int j = 0; j < 178; j++) begin
            if (!tx_ready) low_cnt++;
            if (j == 0) check("tx_idle_at_accept", {31'd0, tx_s}, 32'd1);
            else if (j <= 176) check($sformatf("tx_bit_cycle%0d", j), {31'd0, tx_s}, {31'd0, frame[(j-1)/16]});
            else check("tx_idle_after", {31'd0, tx_s}, 32'd1);
            tick(1);
        end
        check("tx_ready_low_cycles", low_cnt, 32'd176);
        $display("tx frame A5 checked, tx_ready low %0d cycles", low_cnt);

        // Loopback, back-to-back 3C then FF
        loop_sel = 1'b1;
        send_tx(8'h3C);
        send_tx(8'hFF);
        wait_tx_idle();
        tick(20);
        check("lb_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("lb_flags", {28'd0, flags()}, 32'd1);
        pop_check("lb_first", 8'h3C);
        pop_check("lb_second", 8'hFF);
        check("lb_empty", {31'd0, rx_valid}, 32'd0);
        pulse_clear();
        check("lb_int_cleared", {31'd0, rx_interrupt}, 32'd0);
        $display("loopback 3C FF checked");

        // Parity error: 0x01 needs even parity 1, send 0
        loop_sel = 1'b0;
        drive_frame(8'h01, 1'b0, 1'b1);
        check("perr_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("perr_rx_data", {24'd0, rx_data}, 32'h01);
        check("perr_flags", {28'd0, flags()}, 32'b0011);
        pop_check("perr_pop", 8'h01);
        pulse_clear();
        $display("parity error frame checked");

        // Framing error: stop bit low
        drive_frame(8'h55, 1'b0, 1'b0);
        check("ferr_no_push", {31'd0, rx_valid}, 32'd0);
        check("ferr_flags", {28'd0, flags()}, 32'b0100);
        pulse_clear();
        $display("framing error frame checked");

        // Overrun: nine words into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            ov_word[i] = 8'h21 + 8'(i * 19);
            drive_frame(ov_word[i], ^ov_word[i], 1'b1);
        end
        check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_flags", {28'd0, flags()}, 32'b1001);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovr_drain%0d", i), ov_word[i]);
        check("ovr_drained_empty", {31'd0, rx_valid}, 32'd0);
        pulse_clear();
        $display("overrun and drain checked");

        // Glitch: 5-cycle low pulse
        bench_rx = 1'b0;
        tick(5);
        bench_rx = 1'b1;
        tick(40);
        check("glitch_no_push", {31'd0, rx_valid}, 32'd0);
        check("glitch_flags", {28'd0, flags()}, 32'd0);
        $display("glitch checked");

        // clear_interrupt held across the push edge, dropped right after it
        clear_interrupt = 1'b1;
        fork
            drive_frame(8'h5A, ^8'h5A, 1'b1);
            begin
                w = 0;
                while (!rx_valid && w < 400) begin tick(1); w++; end
                clear_interrupt = 1'b0;
            end
        join
        check("setclr_push", {31'd0, rx_valid}, 32'd1);
        check("setclr_data", {24'd0, rx_data}, 32'h5A);
        check("setclr_int", {31'd0, rx_interrupt}, 32'd1);
        $display("set/clear collision checked");

        // Reset during data bit 3 of 0xC3 (bit 3 = 0); FIFO still holds 0x5A
        send_tx(8'hC3);
        tick(16 * 4 + 8);
        check("rst_mid_bit3_low", {31'd0, tx_s}, 32'd0);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_tx", {31'd0, tx_s}, 32'd1);
        check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_mid_fifo_empty", {31'd0, rx_valid}, 32'd0);
        @(negedge clk) rst = 1'b0;
        tick(2);
        check("rst_mid_flags", {28'd0, flags()}, 32'd0);
        loop_sel = 1'b1;
        send_tx(8'h96);
        wait_tx_idle();
        tick(20);
        check("post_rst_valid", {31'd0, rx_valid}, 32'd1);
        check("post_rst_data", {24'd0, rx_data}, 32'h96);
        check("post_rst_flags", {28'd0, flags()}, 32'd1);
        pop_check("post_rst_pop", 8'h96);
        pulse_clear();
        $display("reset mid-frame and recovery checked");

        // Second instance: (1+5+1+2)*4 = 36-cycle frame, loopback of 0x15
        @(negedge clk);
        tx_data2 = 5'h15; tx_valid2 = 1'b1;
        @(posedge clk);
        #1 tx_valid2 = 1'b0;
        low_cnt = 0; w = 0;
        while (!tx_ready2 && w < 200) begin low_cnt++; tick(1); w++; end
        check("p2_tx_ready_low", low_cnt, 32'd36);
        tick(10);
        check("p2_rx_valid", {31'd0, rx_valid2}, 32'd1);
        check("p2_rx_data", {27'd0, rx_data2}, 32'h15);
        check("p2_flags", {28'd0, ovr2, ferr2, perr2, rx_int2}, 32'd1);
        $display("parameter sweep instance loopback 15 checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
